excp_ctrl: RTL



---
 rtl/excp_pkg.sv | 15 +
 rtl/excp_prio.sv | 35 +++
 rtl/excp_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/excp_pkg.sv
// excp_pkg: shared state enum, event codes and CP0 Status/Cause bit positions for excp_ctrl.
package excp_pkg;
  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_e;
  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT = 32'h0000_0004;
  localparam logic [31:0] EXC_SYS = 32'h0000_0100;
  localparam logic [31:0] EXC_ERET = 32'h0000_0200;
  localparam int ST_IE = 0;
  localparam int ST_EXL = 1;
  localparam int IM_LSB = 10;
  localparam int IM_MSB = 15;
  localparam int IP_LSB = 10;
  localparam int IP_MSB = 15;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0040;
endpackage

// File: rtl/excp_prio.sv
// excp_prio: interrupt-pending and interrupt > syscall > eret priority encode; EXCP_HWINT_EN adds Cause.IP & Status.IM.
module excp_prio
  import excp_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        mem_valid_i,
  input  logic        mem_syscall_i,
  input  logic        mem_eret_i,
  input  logic        intimer_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] status_i,
  input  logic [31:0] epc_i,
  output logic [31:0] code_o,
  output logic [31:0] target_o
);
  logic hw;
  logic int_req;
  logic unused_bits;
`ifdef EXCP_HWINT_EN
  assign hw = |(cause_i[IP_MSB:IP_LSB] & status_i[IM_MSB:IM_LSB]);
  assign unused_bits = ^{cause_i[31:IP_MSB+1], cause_i[IP_LSB-1:0], status_i[31:IM_MSB+1], status_i[IM_LSB-1:ST_EXL+1]};
`else
  assign hw = 1'b0;
  assign unused_bits = ^{cause_i, status_i[31:ST_EXL+1]};
`endif
  assign int_req = status_i[ST_IE] & ~status_i[ST_EXL] & (intimer_i | hw);
  always_comb begin
    code_o = !mem_valid_i ? EXC_NONE :
             int_req      ? EXC_INT  :
             mem_syscall_i ? EXC_SYS :
             mem_eret_i   ? EXC_ERET : EXC_NONE;
    target_o = (code_o == EXC_ERET) ? epc_i : EXC_VECTOR;
  end
endmodule

// File: rtl/excp_ctrl.sv
// excp_ctrl: IDLE/COMMIT/REDIRECT sequencer issuing the CP0 exception strobe, flush and fetch redirect.
// Optional external interrupts via EXCP_HWINT_EN (see excp_prio).
module excp_ctrl
  import excp_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_syscall,
  input  logic        mem_eret,
  input  logic        intimer,
  input  logic [31:0] cause,
  input  logic [31:0] status,
  input  logic [31:0] epc,
  output logic [31:0] excptype,
  output logic [31:0] excp_pc,
  output logic        flush,
  output logic        stall_req,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  state_e      state_q;
  logic [31:0] code;
  logic [31:0] target;
  logic [31:0] excptype_q, excp_pc_q, tgt_q, redirect_pc_q;
  logic        flush_q, stall_q, redirect_valid_q;
  excp_prio #(.EXC_VECTOR(EXC_VECTOR)) u_prio (
    .mem_valid_i  (mem_valid),
    .mem_syscall_i(mem_syscall),
    .mem_eret_i   (mem_eret),
    .intimer_i    (intimer),
    .cause_i      (cause),
    .status_i     (status),
    .epc_i        (epc),
    .code_o       (code),
    .target_o     (target)
  );
  // Inputs are only sampled in IDLE; anything seen in COMMIT/REDIRECT is being flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      excptype_q       <= EXC_NONE;
      excp_pc_q        <= '0;
      tgt_q            <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (code != EXC_NONE) begin
          state_q    <= COMMIT;
          excptype_q <= code;
          excp_pc_q  <= mem_pc;
          tgt_q      <= target;
          flush_q    <= 1'b1;
          stall_q    <= 1'b1;
        end
        COMMIT: begin
          state_q          <= REDIRECT;
          excptype_q       <= EXC_NONE;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= tgt_q;
        end
        REDIRECT: begin
          state_q          <= IDLE;
          flush_q          <= 1'b0;
          stall_q          <= 1'b0;
          redirect_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign excptype       = excptype_q;
  assign excp_pc        = excp_pc_q;
  assign flush          = flush_q;
  assign stall_req      = stall_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
endmodule
